session_ctrl: RTL and testbench

// - Downstream of the authentication stage. Consumes its login status, guest flag and user ID.
// - Runs the logged-in game session: start, timer arm/enable, round accounting, player-input gating.
// - Sends the log-out pulse back to the authentication stage on user request, guest quota exhaustion or inactivity.

---
 rtl/session_ctrl_pkg.sv | 26 ++
 rtl/session_ctrl_if.sv | 40 ++++
 rtl/session_idle_timer.sv | 42 ++++
 rtl/session_ctrl.sv | 118 +++++++++++
 tb/tb_session_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/session_ctrl_pkg.sv
// Shared types and constants for the game-session controller:
// state encoding, ID width and the clock-derived idle-timeout default.
package session_ctrl_pkg;

    localparam int          ID_W             = 3;
    localparam int          RND_W            = 4;
    localparam int          CLK_HZ           = 50_000_000;
    localparam int          IDLE_SECONDS     = 30;
    localparam logic [31:0] IDLE_CYCLES_DEF  = 32'(CLK_HZ) * 32'(IDLE_SECONDS);
    localparam int          GUEST_ROUNDS_DEF = 3;

    typedef enum logic [2:0] {
        LOGGED_OUT = 3'd0,
        IDLE       = 3'd1,
        ARM        = 3'd2,
        PLAY       = 3'd3,
        ROUND_END  = 3'd4,
        LOGOUT     = 3'd5
    } state_e;

    // Round counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [RND_W-1:0] rounds_inc(input logic [RND_W-1:0] r);
        return (&r) ? r : r + RND_W'(1);
    endfunction

endpackage

// File: rtl/session_ctrl_if.sv
// Bundle of authentication, player and timer signals around the session controller.
// The master side is the surrounding system; the slave side is session_ctrl.
interface session_ctrl_if #(
    parameter int ID_W = session_ctrl_pkg::ID_W
) ();

    logic            log_in_ctrl;
    logic            isGuest_ctrl;
    logic [ID_W-1:0] intID_ctrl;
    logic            start_in;
    logic            logout_req;
    logic            timeout;
    logic            load_p1_in;
    logic            load_RNG_in;

    logic            log_out_ctrl;
    logic            logged_in;
    logic            logged_out;
    logic            load_p1_out;
    logic            load_RNG_out;
    logic            timer_reconfig;
    logic            timer_enable;
    logic [ID_W-1:0] session_id;
    logic [3:0]      rounds_played;

    modport master (
        output log_in_ctrl, isGuest_ctrl, intID_ctrl, start_in, logout_req,
               timeout, load_p1_in, load_RNG_in,
        input  log_out_ctrl, logged_in, logged_out, load_p1_out, load_RNG_out,
               timer_reconfig, timer_enable, session_id, rounds_played
    );

    modport slave (
        input  log_in_ctrl, isGuest_ctrl, intID_ctrl, start_in, logout_req,
               timeout, load_p1_in, load_RNG_in,
        output log_out_ctrl, logged_in, logged_out, load_p1_out, load_RNG_out,
               timer_reconfig, timer_enable, session_id, rounds_played
    );

endinterface

// File: rtl/session_idle_timer.sv
// Loadable up-counter with synchronous clear and enable; tc_o flags the terminal count.
// The count holds at TERMINAL rather than wrapping.
module session_idle_timer #(
    parameter int           W        = 32,
    parameter logic [W-1:0] TERMINAL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && !tc_o) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TERMINAL);

endmodule

// File: rtl/session_ctrl.sv
// Game-session controller: login latch, round FSM, idle auto-logout and player-input gating.
// Outputs are registered decodes of the next state; only the gated loads are combinational.
module session_ctrl
    import session_ctrl_pkg::*;
#(
    parameter int          GUEST_ROUNDS = GUEST_ROUNDS_DEF,
    parameter logic [31:0] IDLE_CYCLES  = IDLE_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    session_ctrl_if.slave   sif
);

    localparam logic [RND_W-1:0] GUEST_LIMIT = RND_W'(GUEST_ROUNDS);

    state_e           state_q;
    state_e           state_d;
    logic             guest_q;
    logic [ID_W-1:0]  session_id_q;
    logic [RND_W-1:0] rounds_q;
    logic             timeout_prev_q;
    logic             log_out_ctrl_q;
    logic             logged_in_q;
    logic             logged_out_q;
    logic             timer_reconfig_q;
    logic             timer_enable_q;
    logic             idle_tc;
    logic             timeout_rise;

    assign timeout_rise = sif.timeout & ~timeout_prev_q;

    // Preloaded to zero outside IDLE so every IDLE visit starts counting from zero.
    session_idle_timer #(
        .W        (32),
        .TERMINAL (IDLE_CYCLES - 32'd1)
    ) u_idle_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (sif.start_in | sif.load_p1_in),
        .en_i       (state_q == IDLE),
        .load_i     (state_q != IDLE),
        .load_val_i ('0),
        .tc_o       (idle_tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOGGED_OUT: if (sif.log_in_ctrl) state_d = IDLE;
            LOGOUT:     state_d = LOGGED_OUT;
            default: begin
                if (sif.logout_req) begin
                    state_d = LOGOUT;
                end else if (!sif.log_in_ctrl) begin
                    state_d = LOGGED_OUT;
                end else begin
                    unique case (state_q)
                        IDLE: begin
                            if (sif.start_in)                      state_d = ARM;
                            else if (idle_tc && !sif.load_p1_in)   state_d = LOGOUT;
                        end
                        ARM:       state_d = PLAY;
                        PLAY:      if (timeout_rise) state_d = ROUND_END;
                        ROUND_END: state_d = (guest_q && rounds_q == GUEST_LIMIT) ? LOGOUT : IDLE;
                        default:   state_d = LOGGED_OUT;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= LOGGED_OUT;
            guest_q          <= 1'b0;
            session_id_q     <= '0;
            rounds_q         <= '0;
            timeout_prev_q   <= 1'b0;
            log_out_ctrl_q   <= 1'b0;
            logged_in_q      <= 1'b0;
            logged_out_q     <= 1'b1;
            timer_reconfig_q <= 1'b0;
            timer_enable_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            timeout_prev_q   <= sif.timeout;
            log_out_ctrl_q   <= (state_d == LOGOUT);
            timer_reconfig_q <= (state_d == ARM);
            timer_enable_q   <= (state_d == PLAY);
            logged_in_q      <= (state_d inside {IDLE, ARM, PLAY, ROUND_END});
            logged_out_q     <= !(state_d inside {IDLE, ARM, PLAY, ROUND_END});

            // Identity is captured once at login; later changes on the inputs are ignored.
            if (state_q == LOGGED_OUT && state_d == IDLE) begin
                session_id_q <= sif.intID_ctrl;
                guest_q      <= sif.isGuest_ctrl;
                rounds_q     <= '0;
            end else if (state_d == LOGGED_OUT) begin
                session_id_q <= '0;
                guest_q      <= 1'b0;
                rounds_q     <= '0;
            end else if (state_q == PLAY && state_d == ROUND_END) begin
                rounds_q     <= rounds_inc(rounds_q);
            end
        end
    end

    assign sif.log_out_ctrl   = log_out_ctrl_q;
    assign sif.logged_in      = logged_in_q;
    assign sif.logged_out     = logged_out_q;
    assign sif.timer_reconfig = timer_reconfig_q;
    assign sif.timer_enable   = timer_enable_q;
    assign sif.session_id     = session_id_q;
    assign sif.rounds_played  = rounds_q;
    assign sif.load_p1_out    = sif.load_p1_in  & (state_q == PLAY);
    assign sif.load_RNG_out   = sif.load_RNG_in & (state_q == PLAY);

endmodule

// File: tb/tb_session_ctrl.sv
// Self-checking bench for session_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural session model.
module tb_session_ctrl;

    localparam int IDLE_N  = 20;
    localparam int GUEST_N = 2;

    localparam int PH_OUT    = 0;
    localparam int PH_IDLE   = 1;
    localparam int PH_ARM    = 2;
    localparam int PH_PLAY   = 3;
    localparam int PH_REND   = 4;
    localparam int PH_LOGOUT = 5;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   cmp_en      = 1'b0;

    // Behavioural view of the session.
    int m_phase   = PH_OUT;
    int m_quiet   = 0;
    int m_rounds  = 0;
    int m_id      = 0;
    bit m_guest   = 1'b0;
    bit m_prev_to = 1'b0;

    session_ctrl_if sif ();

    session_ctrl #(
        .GUEST_ROUNDS (GUEST_N),
        .IDLE_CYCLES  (32'(IDLE_N))
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] b(input logic v);
        return {31'd0, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_step();
        bit rise;
        int nxt;
        rise      = sif.timeout && !m_prev_to;
        m_prev_to = sif.timeout;
        nxt       = m_phase;
        if (m_phase == PH_OUT) begin
            if (sif.log_in_ctrl) begin
                nxt      = PH_IDLE;
                m_id     = int'(sif.intID_ctrl);
                m_guest  = sif.isGuest_ctrl;
                m_rounds = 0;
            end
        end else if (m_phase == PH_LOGOUT) begin
            nxt = PH_OUT;
        end else if (sif.logout_req) begin
            nxt = PH_LOGOUT;
        end else if (!sif.log_in_ctrl) begin
            nxt = PH_OUT;
        end else if (m_phase == PH_IDLE) begin
            if (sif.start_in)                nxt = PH_ARM;
            else if (sif.load_p1_in)         m_quiet = 0;
            else if (m_quiet == IDLE_N - 1)  nxt = PH_LOGOUT;
            else                             m_quiet++;
        end else if (m_phase == PH_ARM) begin
            nxt = PH_PLAY;
        end else if (m_phase == PH_PLAY) begin
            if (rise) begin
                nxt      = PH_REND;
                m_rounds = (m_rounds < 15) ? m_rounds + 1 : 15;
            end
        end else begin
            nxt = (m_guest && m_rounds == GUEST_N) ? PH_LOGOUT : PH_IDLE;
        end
        if (nxt == PH_OUT) begin
            m_id     = 0;
            m_rounds = 0;
            m_guest  = 1'b0;
        end
        if (nxt == PH_IDLE && m_phase != PH_IDLE) m_quiet = 0;
        m_phase = nxt;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase   = PH_OUT;
            m_quiet   = 0;
            m_rounds  = 0;
            m_id      = 0;
            m_guest   = 1'b0;
            m_prev_to = 1'b0;
        end else begin
            model_step();
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en && !rst) begin
            check("cyc_log_out_ctrl",   b(sif.log_out_ctrl),   b(m_phase == PH_LOGOUT));
            check("cyc_logged_in",      b(sif.logged_in),      b(m_phase >= PH_IDLE && m_phase <= PH_REND));
            check("cyc_logged_out",     b(sif.logged_out),     b(!(m_phase >= PH_IDLE && m_phase <= PH_REND)));
            check("cyc_timer_reconfig", b(sif.timer_reconfig), b(m_phase == PH_ARM));
            check("cyc_timer_enable",   b(sif.timer_enable),   b(m_phase == PH_PLAY));
            check("cyc_load_p1_out",    b(sif.load_p1_out),    b(sif.load_p1_in && m_phase == PH_PLAY));
            check("cyc_load_RNG_out",   b(sif.load_RNG_out),   b(sif.load_RNG_in && m_phase == PH_PLAY));
            check("cyc_session_id",     32'(sif.session_id),   m_id);
            check("cyc_rounds_played",  32'(sif.rounds_played), m_rounds);
        end
    end

    // Assumes IDLE with timeout low; returns one cycle after ROUND_END.
    task automatic play_round();
        sif.start_in = 1'b1;
        cyc();
        sif.start_in = 1'b0;
        cyc();
        sif.timeout = 1'b1;
        cyc();
        sif.timeout = 1'b0;
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit quiet_mode;
        rst              = 1'b1;
        sif.log_in_ctrl  = 1'b0;
        sif.isGuest_ctrl = 1'b0;
        sif.intID_ctrl   = '0;
        sif.start_in     = 1'b0;
        sif.logout_req   = 1'b0;
        sif.timeout      = 1'b0;
        sif.load_p1_in   = 1'b0;
        sif.load_RNG_in  = 1'b0;
        cyc(2);
        check("rst_logged_out",   b(sif.logged_out),     32'd1);
        check("rst_logged_in",    b(sif.logged_in),      32'd0);
        check("rst_session_id",   32'(sif.session_id),   32'd0);
        check("rst_rounds",       32'(sif.rounds_played), 32'd0);
        check("rst_log_out_ctrl", b(sif.log_out_ctrl),   32'd0);
        rst    = 1'b0;
        cmp_en = 1'b1;
        cyc(2);

        // Login and one round.
        sif.intID_ctrl   = 3'd5;
        sif.isGuest_ctrl = 1'b0;
        sif.log_in_ctrl  = 1'b1;
        cyc(2);
        check("login_logged_in", b(sif.logged_in),      32'd1);
        check("login_id",        32'(sif.session_id),   32'd5);
        check("login_rounds",    32'(sif.rounds_played), 32'd0);
        sif.intID_ctrl = 3'd1;
        sif.start_in   = 1'b1;
        cyc();
        sif.start_in   = 1'b0;
        check("arm_reconfig", b(sif.timer_reconfig), 32'd1);
        check("arm_enable",   b(sif.timer_enable),   32'd0);
        cyc();
        check("play_enable",   b(sif.timer_enable),   32'd1);
        check("play_reconfig", b(sif.timer_reconfig), 32'd0);
        check("play_id_held",  32'(sif.session_id),   32'd5);
        sif.load_p1_in  = 1'b1;
        sif.load_RNG_in = 1'b1;
        #1;
        check("play_p1_pass",  b(sif.load_p1_out),  32'd1);
        check("play_rng_pass", b(sif.load_RNG_out), 32'd1);
        sif.load_p1_in  = 1'b0;
        sif.load_RNG_in = 1'b0;
        sif.timeout = 1'b1;
        cyc();
        check("rend_enable", b(sif.timer_enable),   32'd0);
        check("rend_rounds", 32'(sif.rounds_played), 32'd1);
        sif.timeout = 1'b0;
        cyc();
        check("idle_again_in",     b(sif.logged_in),    32'd1);
        check("idle_again_enable", b(sif.timer_enable), 32'd0);

        // Gating outside PLAY.
        sif.load_p1_in  = 1'b1;
        sif.load_RNG_in = 1'b1;
        #1;
        check("idle_p1_gated",  b(sif.load_p1_out),  32'd0);
        check("idle_rng_gated", b(sif.load_RNG_out), 32'd0);
        sif.load_p1_in  = 1'b0;
        sif.load_RNG_in = 1'b0;

        // Timeout already high on PLAY entry does not end the round.
        sif.timeout  = 1'b1;
        cyc();
        sif.start_in = 1'b1;
        cyc();
        sif.start_in = 1'b0;
        cyc(4);
        check("held_to_play", b(sif.timer_enable), 32'd1);
        sif.timeout = 1'b0;
        cyc();
        check("held_to_low", b(sif.timer_enable), 32'd1);
        sif.timeout = 1'b1;
        cyc();
        check("held_to_rise_end", b(sif.timer_enable),   32'd0);
        check("held_to_rounds",   32'(sif.rounds_played), 32'd2);
        sif.timeout = 1'b0;
        cyc();

        // Login dropped mid-PLAY: direct exit, no logout pulse.
        sif.start_in = 1'b1;
        cyc();
        sif.start_in = 1'b0;
        cyc();
        sif.log_in_ctrl = 1'b0;
        cyc();
        check("drop_logged_out", b(sif.logged_out),   32'd1);
        check("drop_no_pulse",   b(sif.log_out_ctrl), 32'd0);
        check("drop_id_clear",   32'(sif.session_id), 32'd0);
        cyc();
        check("drop_no_pulse2",  b(sif.log_out_ctrl), 32'd0);

        // Idle expiry after IDLE_N quiet cycles.
        sif.intID_ctrl  = 3'd2;
        sif.log_in_ctrl = 1'b1;
        cyc();
        cyc(IDLE_N - 1);
        check("idle_last_cycle", b(sif.log_out_ctrl), 32'd0);
        cyc();
        check("idle_expired", b(sif.log_out_ctrl), 32'd1);
        sif.log_in_ctrl = 1'b0;
        cyc();
        check("idle_exit_pulse", b(sif.log_out_ctrl), 32'd0);
        check("idle_exit_out",   b(sif.logged_out),   32'd1);

        // Start on the expiry cycle wins; then logout_req beats a timeout edge.
        sif.log_in_ctrl = 1'b1;
        cyc();
        cyc(IDLE_N - 1);
        sif.start_in = 1'b1;
        cyc();
        sif.start_in = 1'b0;
        check("start_wins_arm",    b(sif.timer_reconfig), 32'd1);
        check("start_wins_nopuls", b(sif.log_out_ctrl),   32'd0);
        cyc();
        sif.logout_req = 1'b1;
        sif.timeout    = 1'b1;
        cyc();
        sif.logout_req = 1'b0;
        check("req_vs_to_pulse",  b(sif.log_out_ctrl),   32'd1);
        check("req_vs_to_rounds", 32'(sif.rounds_played), 32'd0);
        check("req_vs_to_enable", b(sif.timer_enable),   32'd0);
        sif.log_in_ctrl = 1'b0;
        sif.timeout     = 1'b0;
        cyc();
        check("req_exit_out", b(sif.logged_out), 32'd1);

        // Guest quota.
        sif.intID_ctrl   = 3'd3;
        sif.isGuest_ctrl = 1'b1;
        sif.log_in_ctrl  = 1'b1;
        cyc();
        play_round();
        check("guest_r1_in",    b(sif.logged_in),      32'd1);
        check("guest_r1_pulse", b(sif.log_out_ctrl),   32'd0);
        check("guest_r1_rnds",  32'(sif.rounds_played), 32'd1);
        play_round();
        check("guest_quota_pulse", b(sif.log_out_ctrl), 32'd1);
        sif.log_in_ctrl  = 1'b0;
        sif.isGuest_ctrl = 1'b0;
        cyc();
        check("guest_out_pulse", b(sif.log_out_ctrl), 32'd0);
        check("guest_out",       b(sif.logged_out),   32'd1);
        check("guest_out_id",    32'(sif.session_id), 32'd0);

        // Non-guest saturation at 15.
        sif.intID_ctrl  = 3'd6;
        sif.log_in_ctrl = 1'b1;
        cyc();
        repeat (16) play_round();
        check("sat_rounds", 32'(sif.rounds_played), 32'd15);
        check("sat_in",     b(sif.logged_in),      32'd1);
        sif.log_in_ctrl = 1'b0;
        cyc();

        // Async reset mid-PLAY.
        sif.log_in_ctrl = 1'b1;
        cyc();
        sif.start_in = 1'b1;
        cyc();
        sif.start_in = 1'b0;
        cyc();
        check("pre_rst_enable", b(sif.timer_enable), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_enable",    b(sif.timer_enable),   32'd0);
        check("arst_logged_in", b(sif.logged_in),      32'd0);
        check("arst_out",       b(sif.logged_out),     32'd1);
        check("arst_pulse",     b(sif.log_out_ctrl),   32'd0);
        check("arst_id",        32'(sif.session_id),   32'd0);
        check("arst_rounds",    32'(sif.rounds_played), 32'd0);
        cyc();
        rst = 1'b0;
        sif.log_in_ctrl = 1'b0;
        cyc(2);

        // Randomized traffic, checked every cycle by the model.
        quiet_mode = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c % 150 == 0) quiet_mode = ($urandom_range(0, 2) == 0);
            sif.start_in     = !quiet_mode && ($urandom_range(0, 9) == 0);
            sif.load_p1_in   = !quiet_mode && ($urandom_range(0, 19) == 0);
            sif.logout_req   = ($urandom_range(0, 199) == 0);
            sif.load_RNG_in  = 1'($urandom_range(0, 1));
            sif.intID_ctrl   = 3'($urandom_range(0, 7));
            sif.isGuest_ctrl = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) sif.timeout = ~sif.timeout;
            if (!sif.log_in_ctrl) begin
                if ($urandom_range(0, 9) == 0) sif.log_in_ctrl = 1'b1;
            end else if (sif.log_out_ctrl || $urandom_range(0, 599) == 0) begin
                sif.log_in_ctrl = 1'b0;
            end
        end
        @(negedge clk);
        cmp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
